// File: rtl/maxpool_pkg.sv
// ============================================================================
// Module      : maxpool_pkg
// Description : Shared FSM state type and max2 compare for the 2x2 max-pool
//               scheduler. Define MAXPOOL_SIGNED_EN for signed comparisons.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package maxpool_pkg;

   localparam int MAX_W = 64;

`ifdef MAXPOOL_SIGNED_EN
   localparam bit SIGNED_CMP = 1'b1;
`else
   localparam bit SIGNED_CMP = 1'b0;
`endif

   typedef enum logic [0:0] {
      EVEN_ROW = 1'b0,
      ODD_ROW  = 1'b1
   } pool_state_e;

   // Operands arrive zero-extended; flipping the sign bit turns a signed
   // compare into an unsigned one at any DATA_W up to MAX_W.
   function automatic logic [MAX_W-1:0] max2(input logic [MAX_W-1:0] a,
                                             input logic [MAX_W-1:0] b,
                                             input logic [MAX_W-1:0] sign_mask);
      logic [MAX_W-1:0] bias;
      bias = SIGNED_CMP ? sign_mask : '0;
      return ((a ^ bias) >= (b ^ bias)) ? a : b;
   endfunction

endpackage

`default_nettype wire

// File: rtl/maxpool_linebuf.sv
// ============================================================================
// Module      : maxpool_linebuf
// Description : One-write/one-read line buffer holding horizontal pair maxima
//               of an even row; combinational read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module maxpool_linebuf #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16,
   parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              wr_en_i,
   input  logic [AW-1:0]     wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic [AW-1:0]     rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

`default_nettype wire

// File: rtl/maxpool_scheduler.sv
// ============================================================================
// Module      : maxpool_scheduler
// Description : Streaming 2x2 stride-2 max-pool over a raster frame.
//               Define MAXPOOL_SIGNED_EN for two's-complement comparisons.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module maxpool_scheduler
   import maxpool_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int IMG_W  = 32,
   parameter int IMG_H  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              frame_err
);

   localparam int COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 1;
   localparam int ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 1;
   localparam int LB_D  = (IMG_W >= 2) ? IMG_W / 2 : 1;
   localparam int LB_AW = (LB_D > 1) ? $clog2(LB_D) : 1;
   localparam logic [MAX_W-1:0] SIGN_MASK = MAX_W'(1) << (DATA_W - 1);

   generate
      if ((IMG_W < 2) || (IMG_W % 2 != 0) || (IMG_H < 2) || (IMG_H % 2 != 0)
          || (DATA_W < 1) || (DATA_W > MAX_W)) begin : g_param_check
         $fatal(1, "maxpool_scheduler: IMG_W/IMG_H must be even and >= 2, DATA_W in 1..64");
      end
   endgenerate

   function automatic logic [DATA_W-1:0] mx(input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
      return DATA_W'(max2(MAX_W'(a), MAX_W'(b), SIGN_MASK));
   endfunction

   pool_state_e       state_q, state_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [DATA_W-1:0] hreg_q, hreg_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_last_q, out_last_d;
   logic              frame_err_q, frame_err_d;

   logic              w_accept;
   logic              w_col_end;
   logic              w_row_end;
   logic              w_final_pos;
   logic              w_lb_we;
   logic [LB_AW-1:0]  w_lb_addr;
   logic [DATA_W-1:0] w_lb_rdata;
   logic [DATA_W-1:0] w_hmax;
   logic [DATA_W-1:0] w_pool;

   assign in_ready    = !out_valid_q || out_ready;
   assign w_accept    = in_valid && in_ready;
   assign w_col_end   = (col_q == COL_W'(IMG_W - 1));
   assign w_row_end   = (row_q == ROW_W'(IMG_H - 1));
   assign w_final_pos = w_col_end && w_row_end;
   assign w_lb_addr   = LB_AW'(col_q >> 1);
   assign w_hmax      = mx(hreg_q, in_data);
   assign w_pool      = mx(w_hmax, w_lb_rdata);

   maxpool_linebuf #(
      .DATA_W (DATA_W),
      .DEPTH  (LB_D),
      .AW     (LB_AW)
   ) u_linebuf (
      .clk       (clk),
      .wr_en_i   (w_lb_we),
      .wr_addr_i (w_lb_addr),
      .wr_data_i (w_hmax),
      .rd_addr_i (w_lb_addr),
      .rd_data_o (w_lb_rdata)
   );

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      hreg_d      = hreg_q;
      out_valid_d = out_valid_q && !out_ready;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q && !out_ready;
      frame_err_d = 1'b0;
      w_lb_we     = 1'b0;

      if (w_accept) begin
         if (in_last != w_final_pos) begin
            // Resync: the offending pixel is dropped, any held output stays.
            frame_err_d = 1'b1;
            col_d       = '0;
            row_d       = '0;
            state_d     = EVEN_ROW;
         end else begin
            if (!col_q[0]) begin
               hreg_d = in_data;
            end else if (state_q == EVEN_ROW) begin
               w_lb_we = 1'b1;
            end else begin
               out_valid_d = 1'b1;
               out_data_d  = w_pool;
               out_last_d  = w_final_pos;
            end

            if (w_col_end) begin
               col_d   = '0;
               row_d   = w_row_end ? '0 : row_q + ROW_W'(1);
               state_d = (state_q == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
            end else begin
               col_d = col_q + COL_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= EVEN_ROW;
         col_q       <= '0;
         row_q       <= '0;
         hreg_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         hreg_q      <= hreg_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign frame_err = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_maxpool_scheduler.sv
// ============================================================================
// Module      : tb_maxpool_scheduler
// Description : Scoreboard bench for maxpool_scheduler on a 4x4 frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_maxpool_scheduler;

   localparam int DW = 16;
   localparam int W  = 4;
   localparam int H  = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          in_last = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          frame_err;

   maxpool_scheduler #(
      .DATA_W (DW),
      .IMG_W  (W),
      .IMG_H  (H)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] d;
      logic          l;
   } exp_t;

   exp_t          sbq[$];
   int            n_cmp = 0;
   int            n_bad = 0;
   int            err_seen = 0;
   int            err_exp = 0;
   int            rdy_mode = 0;
   logic [DW-1:0] frm [W*H];

   function automatic logic [DW-1:0] ref_max(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef MAXPOOL_SIGNED_EN
      return ($signed(a) >= $signed(b)) ? a : b;
`else
      return (a >= b) ? a : b;
`endif
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Every complete 2x2 block whose bottom-right pixel is among the first npix
   // pixels yields one pooled output.
   task automatic expect_frame(input int npix);
      for (int by = 0; by < H / 2; by++) begin
         for (int bx = 0; bx < W / 2; bx++) begin
            int            tl;
            int            br;
            logic [DW-1:0] m;
            tl = (2 * by) * W + 2 * bx;
            br = tl + W + 1;
            if (br < npix) begin
               m = ref_max(ref_max(frm[tl], frm[tl + 1]), ref_max(frm[br - 1], frm[br]));
               sbq.push_back('{d: m, l: (by == H / 2 - 1) && (bx == W / 2 - 1)});
            end
         end
      end
   endtask

   task automatic send_px(input logic [DW-1:0] d, input logic last);
      int t;
      t = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         t++;
         if (t > 1000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL in_handshake: got in_ready=0 for 1000 cycles, expected acceptance");
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_frame(input int from, input int upto, input int last_at, input bit gaps);
      for (int i = from; i < upto; i++) begin
         if (gaps && ($urandom_range(0, 3) == 0)) begin
            repeat ($urandom_range(1, 3)) begin
               @(posedge clk);
               #1;
            end
         end
         send_px(frm[i], i == last_at);
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sbq.size() != 0 && t < 500) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("drain_pending", 64'(sbq.size()), 64'd0);
   endtask

   task automatic check_reset_state();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_last", 64'(out_last), 64'd0);
      check("rst_frame_err", 64'(frame_err), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
   endtask

   task automatic load_ramp(input bit invert);
      for (int i = 0; i < W * H; i++) begin
         frm[i] = invert ? DW'(W * H - i) : DW'(i + 1);
      end
   endtask

   task automatic load_random();
      for (int i = 0; i < W * H; i++) begin
         frm[i] = DW'($urandom);
      end
   endtask

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0: out_ready = 1'b1;
         1: out_ready = ($urandom_range(0, 3) != 0);
         default: ;
      endcase
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (frame_err) err_seen++;
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_output: got data %0h, expected no output", out_data);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               check("out_data", 64'(out_data), 64'(e.d));
               check("out_last", 64'(out_last), 64'(e.l));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_state();
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Ascending and descending ramps
      load_ramp(1'b0);
      expect_frame(W * H);
      send_frame(0, W * H, W * H - 1, 1'b0);
      load_ramp(1'b1);
      expect_frame(W * H);
      send_frame(0, W * H, W * H - 1, 1'b0);
      drain();

      // Output held for 5 cycles after the first pooled pixel
      rdy_mode  = 2;
      out_ready = 1'b1;
      load_ramp(1'b0);
      expect_frame(W * H);
      send_frame(0, 6, W * H - 1, 1'b0);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = frm[6];
      in_last   = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("stall_in_ready", 64'(in_ready), 64'd0);
         check("stall_out_valid", 64'(out_valid), 64'd1);
         check("stall_out_data", 64'(out_data), 64'd6);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      send_frame(6, W * H, W * H - 1, 1'b0);
      drain();
      rdy_mode = 0;

      // Early in_last on pixel 10, then a clean frame
      load_ramp(1'b0);
      expect_frame(10);
      err_exp++;
      send_frame(0, 10, 9, 1'b0);
      drain();
      expect_frame(W * H);
      send_frame(0, W * H, W * H - 1, 1'b0);
      drain();

      // Reset after pixel 7, then a full frame
      expect_frame(7);
      send_frame(0, 7, W * H - 1, 1'b0);
      drain();
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset_state();
      @(posedge clk);
      #1;
      reset = 1'b0;
      expect_frame(W * H);
      send_frame(0, W * H, W * H - 1, 1'b0);
      drain();

      // Sign-sensitive block in the top-left corner
      load_random();
      frm[0]     = 16'hFFFF;
      frm[1]     = 16'h0001;
      frm[W]     = 16'h8000;
      frm[W + 1] = 16'h0000;
      expect_frame(W * H);
      send_frame(0, W * H, W * H - 1, 1'b1);
      drain();

      // Random frames under random backpressure and input gaps
      rdy_mode = 1;
      repeat (8) begin
         load_random();
         expect_frame(W * H);
         send_frame(0, W * H, W * H - 1, 1'b1);
      end
      rdy_mode = 0;
      drain();

      repeat (3) @(posedge clk);
      check("frame_err_cycles", 64'(err_seen), 64'(err_exp));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
